opb_register_bank_ppc2simulink: RTL and testbench
=================================================

Name: opb_register_bank_ppc2simulink

Overview:
Parametrised successor to the single-word PPC-to-Simulink software register. It provides C_NUM_REGS 32-bit control registers behind one OPB slave window, with byte-enable writes, readback, per-register write strobes and an optional double-buffered mode. In double-buffered mode, all registers update atomically on a commit write. The block sits on the OPB and drives user logic directly in the OPB_Clk domain.

Parameters:
C_BASEADDR, 32'h01000200, first byte address of the window.
C_HIGHADDR, 32'h010002FF, last byte address of the window.
C_OPB_AWIDTH, 32, OPB address width.
C_OPB_DWIDTH, 32, OPB data width; only 32 is supported.
C_NUM_REGS, 4, number of registers, 1..16.
C_DOUBLE_BUF, 0, 1 = shadow plus live registers with a commit address.
C_RST_VAL, 32'h00000000, reset value of every shadow and live register.

Ports:
OPB_Clk  in  1  sole clock.
OPB_Rst_n  in  1  synchronous, active-low reset.
OPB_ABus  in  [0:31]  address.
OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7] (MSB byte).
OPB_DBus  in  [0:31]  write data.
OPB_RNW  in  1  1 = read.
OPB_select  in  1  transfer request.
OPB_seqAddr  in  1  ignored.
Sl_DBus  out  [0:31]  read data; 0 except during xferAck.
Sl_xferAck  out  1  one-cycle transfer acknowledge.
Sl_errAck  out  1  error acknowledge for unmapped offsets.
Sl_retry  out  1  tied 0.
Sl_toutSup  out  1  tied 0.
user_data_out  out  [32*C_NUM_REGS-1:0]  live registers; reg i occupies bits [32i+31:32i].
user_wr_stb  out  [C_NUM_REGS-1:0]  one-cycle pulse per live-register update.
user_commit  out  1  one-cycle pulse on commit (double-buffered mode only; otherwise 0).

Behaviour:
- Reset: the reset is synchronous and active-low. While OPB_Rst_n = 0 at a rising edge:
  - all shadow and live registers load C_RST_VAL;
  - Sl_* outputs, user_wr_stb and user_commit are 0;
  - the FSM goes to IDLE.
  - Reset mid-transfer aborts the transfer: no ack is issued and no register is written.
- Address map:
  - reg i is at C_BASEADDR + 4*i;
  - the commit word is at C_BASEADDR + 4*C_NUM_REGS (double-buffered mode only);
  - any other in-window offset is "unmapped";
  - out-of-window addresses produce no response (all outputs stay 0).
- FSM states IDLE, ACK, GAP:
  - IDLE -> ACK when OPB_select = 1 and the address is in-window, sampled at edge k.
  - In ACK, Sl_xferAck = 1 for exactly cycle k+1. Sl_errAck = 1 in the same cycle if the offset is unmapped.
  - ACK -> GAP, then GAP -> IDLE. GAP is a dead cycle that prevents a double ack while select is still high.
  - Minimum spacing between acks is therefore 3 cycles.
- Reads:
  - Sl_DBus is registered and valid only while xferAck = 1; it returns the addressed shadow register (equal to live when C_DOUBLE_BUF = 0).
  - Reads of the commit word or of unmapped offsets return 0.
- Writes:
  - Each byte n with BE[n] = 1 replaces the corresponding byte; other bytes hold.
  - BE = 0000 writes nothing but is still acked.
  - OPB bit j maps to user bit 31-j.
- C_DOUBLE_BUF = 0:
  - The live register updates at the edge ending cycle k+1.
  - user_wr_stb[i] = 1 during cycle k+2, aligned with the first cycle the new value is visible.
- C_DOUBLE_BUF = 1:
  - A register write updates only the shadow; user_data_out is unchanged.
  - A write to the commit word with OPB_DBus[31] = 1 copies all shadows to live at the edge ending cycle k+1. user_commit = 1 and every user_wr_stb bit = 1 in cycle k+2.
  - A commit write with DBus[31] = 0 is acked with no effect.
  - A register write followed by a commit commits the new value, since the two transfers are sequential and at least 3 cycles apart.
- Unmapped writes: acked with errAck; no state changes.

Decomposition:
- Shared package opb_regbank_pkg holds:
  - the FSM state enum {IDLE, ACK, GAP};
  - ADDR_STRIDE = 4;
  - MAX_REGS = 16;
  - the byte-lane mapping function (BE bit to user byte).
- One sub-module, opb_reg_slice, is instantiated C_NUM_REGS times. It holds:
  - the shadow register with byte-enable merge;
  - the live register;
  - strobe generation.

Test Plan:
- Reset, then read reg 2 (C_NUM_REGS = 4) -> xferAck exactly one cycle after select sampled; Sl_DBus = 0x00000000; Sl_DBus = 0 outside the ack cycle.
- Single-buffered: write 0xDEADBEEF to reg 1 with BE = 1111 -> user_data_out[63:32] = 0xDEADBEEF and user_wr_stb = 0010 for one cycle at k+2.
- Byte merge: write 0x11223344 with BE = 0110 over 0xDEADBEEF -> reg = 0xDE2233EF; readback matches.
- Double-buffered: write 0xA5A5A5A5 to reg 0 -> user_data_out unchanged; write 0x00000001 to commit -> reg 0 live = 0xA5A5A5A5, user_commit pulses one cycle, user_wr_stb = 1111.
- Hold select high for 6 cycles on reg 3 -> acks at k+1 and k+4 only, never on consecutive cycles. Access offset 0x40 -> errAck with xferAck, no register changes. Access C_HIGHADDR + 4 -> no response.
- Assert OPB_Rst_n = 0 in the cycle after select -> no xferAck; all registers = C_RST_VAL; FSM accepts a new transfer after reset.

Source files
------------

// File: rtl/opb_regbank_pkg.sv
// Shared types, constants and byte-lane helper for the OPB register bank.
package opb_regbank_pkg;

  typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;

  localparam int ADDR_STRIDE = 4;
  localparam int MAX_REGS    = 16;

  // OPB BE[n] covers DBus[8n:8n+7], i.e. user byte 3-n once bits are reversed.
  function automatic logic [31:0] be_to_mask(input logic [0:3] be);
    logic [31:0] mask;
    mask = '0;
    for (int n = 0; n < 4; n++) begin
      mask[8*(3-n) +: 8] = {8{be[n]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/opb_reg_slice.sv
// One control register: shadow with byte merge, live copy and update strobe.
module opb_reg_slice
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_RST_VAL    = 32'h0000_0000,
  parameter bit          C_DOUBLE_BUF = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_mask,
  input  logic [31:0] wr_data,
  input  logic        commit,
  output logic [31:0] shadow,
  output logic [31:0] live,
  output logic        wr_stb
);

  logic [31:0] shadow_reg;
  logic [31:0] live_reg;
  logic [31:0] merged_next;
  logic        stb_reg;

  assign merged_next = (shadow_reg & ~wr_mask) | (wr_data & wr_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_reg <= C_RST_VAL;
      live_reg   <= C_RST_VAL;
      stb_reg    <= 1'b0;
    end else begin
      stb_reg <= 1'b0;
      if (wr_en) begin
        shadow_reg <= merged_next;
      end
      if (C_DOUBLE_BUF) begin
        if (commit) begin
          live_reg <= shadow_reg;
          stb_reg  <= 1'b1;
        end
      end else if (wr_en && (|wr_mask)) begin
        // An all-zero byte enable changes nothing, so it raises no strobe.
        live_reg <= merged_next;
        stb_reg  <= 1'b1;
      end
    end
  end

  assign shadow = shadow_reg;
  assign live   = live_reg;
  assign wr_stb = stb_reg;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS 32-bit control registers to user logic,
// optionally double-buffered with an atomic commit word.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0200,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_02FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter int          C_DOUBLE_BUF = 0,
  parameter logic [31:0] C_RST_VAL    = 32'h0000_0000
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]   user_wr_stb,
  output logic                    user_commit
);

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] offset;
  logic        in_win;
  logic        is_reg;
  logic        is_commit;
  logic [3:0]  idx;

  state_t      state_reg;
  logic        ack_reg;
  logic        err_reg;
  logic [31:0] dbus_reg;
  logic        wr_pend_reg;
  logic        commit_pend_reg;
  logic        commit_stb_reg;
  logic [3:0]  idx_reg;
  logic [31:0] mask_reg;
  logic [31:0] data_reg;
  logic [31:0] shadow_q [MAX_REGS];

  // Plain vector assignment reverses the OPB big-endian bit numbering.
  assign addr      = OPB_ABus;
  assign wdata     = OPB_DBus;
  assign in_win    = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign offset    = addr - C_BASEADDR;
  assign is_reg    = (offset[1:0] == 2'b00) && ({2'b00, offset[31:2]} < 32'(C_NUM_REGS));
  assign is_commit = (C_DOUBLE_BUF != 0) && (offset == 32'(ADDR_STRIDE * C_NUM_REGS));
  assign idx       = offset[5:2];

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_reg       <= IDLE;
      ack_reg         <= 1'b0;
      err_reg         <= 1'b0;
      dbus_reg        <= '0;
      wr_pend_reg     <= 1'b0;
      commit_pend_reg <= 1'b0;
      commit_stb_reg  <= 1'b0;
      idx_reg         <= '0;
      mask_reg        <= '0;
      data_reg        <= '0;
    end else begin
      ack_reg         <= 1'b0;
      err_reg         <= 1'b0;
      dbus_reg        <= '0;
      wr_pend_reg     <= 1'b0;
      commit_pend_reg <= 1'b0;
      commit_stb_reg  <= commit_pend_reg;
      case (state_reg)
        IDLE: begin
          if (OPB_select && in_win) begin
            state_reg       <= ACK;
            ack_reg         <= 1'b1;
            err_reg         <= !(is_reg || is_commit);
            dbus_reg        <= (OPB_RNW && is_reg) ? shadow_q[idx] : 32'h0;
            wr_pend_reg     <= !OPB_RNW && is_reg;
            commit_pend_reg <= !OPB_RNW && is_commit && wdata[0];
            idx_reg         <= idx;
            mask_reg        <= be_to_mask(OPB_BE);
            data_reg        <= wdata;
          end
        end
        ACK:     state_reg <= GAP;
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_REGS; gi++) begin : g_reg
      if (gi < C_NUM_REGS) begin : g_slice
        opb_reg_slice #(
          .C_RST_VAL    (C_RST_VAL),
          .C_DOUBLE_BUF (C_DOUBLE_BUF != 0)
        ) u_slice (
          .clk     (OPB_Clk),
          .rst_n   (OPB_Rst_n),
          .wr_en   (wr_pend_reg && (idx_reg == 4'(gi))),
          .wr_mask (mask_reg),
          .wr_data (data_reg),
          .commit  (commit_pend_reg),
          .shadow  (shadow_q[gi]),
          .live    (user_data_out[32*gi +: 32]),
          .wr_stb  (user_wr_stb[gi])
        );
      end else begin : g_none
        assign shadow_q[gi] = '0;
      end
    end
  endgenerate

  // Masking with the reset keeps a transfer aborted mid-flight from acking.
  assign Sl_xferAck  = ack_reg & OPB_Rst_n;
  assign Sl_errAck   = err_reg & OPB_Rst_n;
  assign Sl_DBus     = dbus_reg & {32{OPB_Rst_n}};
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_commit = commit_stb_reg;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Checks a single-buffered and a double-buffered bank on a shared OPB bus.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h0100_0200;
  localparam logic [31:0] HIGH = 32'h0100_02FF;
  localparam int          NREG = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] dbus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;

  logic [0:31]  sb_dbus, db_dbus;
  logic         sb_ack, db_ack, sb_err, db_err, sb_retry, db_retry, sb_tout, db_tout;
  logic [127:0] sb_data, db_data;
  logic [3:0]   sb_stb, db_stb;
  logic         sb_cmt, db_cmt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_m [NREG];
  logic [31:0] sh_m [NREG];
  logic [31:0] lv_m [NREG];

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(.C_DOUBLE_BUF(0)) dut_sb (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sb_dbus),
    .Sl_xferAck(sb_ack), .Sl_errAck(sb_err), .Sl_retry(sb_retry), .Sl_toutSup(sb_tout),
    .user_data_out(sb_data), .user_wr_stb(sb_stb), .user_commit(sb_cmt));

  opb_register_bank_ppc2simulink #(.C_DOUBLE_BUF(1)) dut_db (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(db_dbus),
    .Sl_xferAck(db_ack), .Sl_errAck(db_err), .Sl_retry(db_retry), .Sl_toutSup(db_tout),
    .user_data_out(db_data), .user_wr_stb(db_stb), .user_commit(db_cmt));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [31:0] r [NREG]);
    logic [127:0] v;
    for (int i = 0; i < NREG; i++) v[32*i +: 32] = r[i];
    return v;
  endfunction

  // User byte (3-n) is replaced when OPB byte enable n is set.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [0:3] b);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) if (b[n]) r[8*(3-n) +: 8] = nw[8*(3-n) +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      sb_m[i] = '0; sh_m[i] = '0; lv_m[i] = '0;
    end
  endtask

  task automatic xfer(input logic [31:0] addr, input logic rnw_i, input logic [0:3] be_i,
                      input logic [31:0] data_i, input string tag);
    int          off, ri;
    bit          in_win, is_reg, is_cmt;
    logic [31:0] rd_sb, rd_db;
    logic [3:0]  stb_sb, stb_db;
    bit          cmt;
    in_win = (addr >= BASE) && (addr <= HIGH);
    off    = int'(addr - BASE);
    is_reg = in_win && (off % 4 == 0) && (off / 4 < NREG);
    is_cmt = in_win && (off == 4 * NREG);
    ri     = is_reg ? off / 4 : 0;
    rd_sb  = (rnw_i && is_reg) ? sb_m[ri] : 32'h0;
    rd_db  = (rnw_i && is_reg) ? sh_m[ri] : 32'h0;
    stb_sb = '0; stb_db = '0; cmt = 0;
    if (!rnw_i && is_reg) begin
      sb_m[ri] = merge(sb_m[ri], data_i, be_i);
      sh_m[ri] = merge(sh_m[ri], data_i, be_i);
      if (be_i != 4'b0000) stb_sb[ri] = 1'b1;
    end
    if (!rnw_i && is_cmt && data_i[0]) begin
      for (int i = 0; i < NREG; i++) lv_m[i] = sh_m[i];
      stb_db = 4'hF; cmt = 1;
    end
    abus = addr; dbus = data_i; be = be_i; rnw = rnw_i; sel = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0;
    chk({tag, " sb_ack"}, sb_ack, in_win);
    chk({tag, " sb_err"}, sb_err, in_win && !is_reg);
    chk({tag, " sb_rd"},  sb_dbus, rd_sb);
    chk({tag, " db_ack"}, db_ack, in_win);
    chk({tag, " db_err"}, db_err, in_win && !is_reg && !is_cmt);
    chk({tag, " db_rd"},  db_dbus, rd_db);
    chk({tag, " stb_early"}, {db_cmt, db_stb, sb_stb}, 9'h0);
    @(posedge clk); #1;
    chk({tag, " ack_gap"}, {sb_ack, db_ack, sb_err, db_err}, 4'h0);
    chk({tag, " dbus_gap"}, {sb_dbus, db_dbus}, 64'h0);
    chk({tag, " sb_stb"}, sb_stb, stb_sb);
    chk({tag, " db_stb"}, db_stb, stb_db);
    chk({tag, " db_cmt"}, db_cmt, cmt);
    chk({tag, " sb_data"}, sb_data, pack(sb_m));
    chk({tag, " db_data"}, db_data, pack(lv_m));
    @(posedge clk); #1;
    $display("xfer %s addr=%h rnw=%0d be=%b data=%h", tag, addr, rnw_i, be_i, data_i);
  endtask

  initial begin
    logic [31:0] a;
    logic [0:3]  b;
    int          ri;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {sb_ack, sb_err, db_ack, db_err, sb_dbus, db_dbus}, 68'h0);
    chk("rst_user", {sb_stb, db_stb, sb_cmt, db_cmt}, 10'h0);
    chk("rst_tied", {sb_retry, sb_tout, db_retry, db_tout}, 4'h0);
    chk("rst_sb_data", sb_data, 128'h0);
    chk("rst_db_data", db_data, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(BASE + 8, 1'b1, 4'b1111, 32'h0, "rd_reg2_rst");
    xfer(BASE + 4, 1'b0, 4'b1111, 32'hDEAD_BEEF, "wr_reg1");
    xfer(BASE + 4, 1'b0, 4'b0110, 32'h1122_3344, "merge_reg1");
    xfer(BASE + 4, 1'b1, 4'b1111, 32'h0, "rd_reg1");
    chk("merge_value", sb_m[1], 32'hDE22_33EF);
    xfer(BASE + 4, 1'b0, 4'b0000, 32'hFFFF_FFFF, "be0_reg1");
    xfer(BASE + 0, 1'b0, 4'b1111, 32'hA5A5_A5A5, "wr_reg0");
    xfer(BASE + 16, 1'b0, 4'b1111, 32'h0000_0000, "commit_nop");
    xfer(BASE + 16, 1'b0, 4'b1111, 32'h0000_0001, "commit");
    chk("commit_reg0", db_data[31:0], 32'hA5A5_A5A5);
    xfer(BASE + 32'h40, 1'b0, 4'b1111, 32'h1234_5678, "unmapped_wr");
    xfer(BASE + 32'h40, 1'b1, 4'b1111, 32'h0, "unmapped_rd");
    xfer(BASE + 6, 1'b0, 4'b1111, 32'h1234_5678, "unaligned");
    xfer(HIGH + 4, 1'b0, 4'b1111, 32'h1234_5678, "out_of_win");

    // Select held for six sampled edges: acks only in the 1st and 4th cycles.
    abus = BASE + 12; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_ack_c%0d", c), {sb_ack, db_ack}, (c == 1 || c == 4) ? 2'b11 : 2'b00);
      if (c == 5) sel = 1'b0;
    end
    $display("xfer hold_sel addr=%h six cycles", BASE + 12);
    @(posedge clk); #1;

    for (int t = 0; t < 24; t++) begin
      ri = int'($urandom_range(0, NREG));
      a  = BASE + 32'(4 * ri);
      b  = 4'($urandom);
      xfer(a, 1'($urandom), b, $urandom, $sformatf("rand%0d", t));
    end

    // Reset drops in the cycle after select was sampled: the transfer dies.
    abus = BASE + 4; dbus = 32'h1234_5678; be = 4'b1111; rnw = 1'b0; sel = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; rst_n = 1'b0;
    #1;
    chk("abort_ack", {sb_ack, db_ack, sb_err, db_err}, 4'h0);
    @(posedge clk); #1;
    model_reset();
    chk("abort_sb_data", sb_data, 128'h0);
    chk("abort_db_data", db_data, 128'h0);
    chk("abort_stb", {sb_stb, db_stb, sb_cmt, db_cmt}, 10'h0);
    $display("xfer abort_by_reset addr=%h", BASE + 4);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(BASE + 4, 1'b1, 4'b1111, 32'h0, "rd_after_rst");
    xfer(BASE + 12, 1'b0, 4'b1001, 32'hCAFE_F00D, "wr_after_rst");
    xfer(BASE + 16, 1'b0, 4'b0001, 32'h8000_0001, "commit_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
